// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: keeps at most one memory request in flight and queues fetched
// instructions in a 2-entry buffer for decode; exceptions, interrupts and branches redirect the PC.
module if_fetch_unit #(
   parameter logic [31:0] ILLOP = 32'h80000004,
   parameter logic [31:0] XADR  = 32'h80000008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC,
   output logic        PCWr,
   output logic [31:0] PC_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        illop,
   input  logic        irq,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t      state, state_next;
   logic [31:0] req_pc;
   logic [31:0] buf_pc    [2];
   logic [31:0] buf_instr [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  count;

   logic        redirect_event;
   logic [31:0] redirect_target;
   logic        fetch_grant;
   logic        push;
   logic        pop;

   assign imem_addr = PC;

   // Interrupts are masked while the PC sits in the kernel half of the address space.
   always_comb begin
      redirect_event  = illop | (irq & ~PC[31]) | redirect;
      redirect_target = redirect_pc;
      if (illop)
         redirect_target = ILLOP;
      else if (irq & ~PC[31])
         redirect_target = XADR;

      imem_req    = reset && (state == IDLE) && !redirect_event && (count < 2'd2);
      fetch_grant = imem_req & imem_gnt;
      push        = (state == WAIT) & imem_rvalid & ~redirect_event;

      PCWr  = reset & (redirect_event | fetch_grant);
      PC_in = PC;
      if (reset && redirect_event)
         PC_in = redirect_target;
      else if (fetch_grant)
         PC_in = {PC[31], PC[30:0] + 31'd4};

      id_valid = reset && (count != 2'd0);
      id_pc    = id_valid ? buf_pc[rd_ptr]    : 32'd0;
      id_instr = id_valid ? buf_instr[rd_ptr] : 32'd0;
      pop      = id_valid & id_ready;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (!redirect_event && fetch_grant) state_next = WAIT;
         WAIT: begin
            if (imem_rvalid)
               state_next = IDLE;
            else if (redirect_event)
               state_next = DROP;
         end
         // A stale response still has to be drained before a new request can go out.
         DROP: if (imem_rvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         req_pc <= 32'd0;
      end else begin
         if (fetch_grant)
            req_pc <= PC;
         if (redirect_event) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            if (push)
               wr_ptr <= ~wr_ptr;
            if (pop)
               rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr]    <= req_pc;
         buf_instr[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the fetch pipeline.
module tb_if_fetch_unit;

   localparam logic [31:0] ILLOP_V = 32'h80000004;
   localparam logic [31:0] XADR_V  = 32'h80000008;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] PC = 32'd0;
   logic        PCWr;
   logic [31:0] PC_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        illop = 1'b0;
   logic        irq = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready = 1'b0;

   always #5 clk = ~clk;

   if_fetch_unit #(.ILLOP(ILLOP_V), .XADR(XADR_V)) dut (
      .clk(clk), .reset(reset), .PC(PC), .PCWr(PCWr), .PC_in(PC_in),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .illop(illop), .irq(irq),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   int checks = 0;
   int errors = 0;

   entry_t      fifo_q[$];
   bit          m_out, m_discard;
   logic [31:0] m_req_pc;
   logic [31:0] pc_reg = 32'd0;

   bit          s_reset, s_gnt, s_ready, s_redirect, s_illop, s_irq, s_spurious;
   logic [31:0] s_redirect_pc, s_rdata_next;
   int          forced_lat = -1;

   bit          mem_pending = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_data = 32'd0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idleInputs();
      s_reset = 1; s_gnt = 0; s_ready = 1; s_redirect = 0; s_illop = 0; s_irq = 0;
      s_spurious = 0; s_redirect_pc = 32'd0; s_rdata_next = $urandom; forced_lat = -1;
   endtask

   // One clock: drive at negedge, check combinational outputs, then advance the model.
   task automatic runCycle();
      bit          ev, grant, exp_req, exp_pcwr, exp_valid, rv;
      logic [31:0] target, seq, exp_pcin, rd;
      @(negedge clk);
      reset = s_reset; PC = pc_reg; imem_gnt = s_gnt; id_ready = s_ready;
      redirect = s_redirect; redirect_pc = s_redirect_pc; illop = s_illop; irq = s_irq;
      rv = 0; rd = $urandom;
      if (mem_pending && mem_cnt == 0) begin
         rv = 1; rd = mem_data;
      end else if (s_spurious && !mem_pending) begin
         rv = 1;
      end
      imem_rvalid = rv; imem_rdata = rd;
      #1;
      ev     = s_illop || (s_irq && pc_reg < 32'h80000000) || s_redirect;
      target = s_illop ? ILLOP_V : ((s_irq && pc_reg < 32'h80000000) ? XADR_V : s_redirect_pc);
      seq    = (pc_reg & 32'h80000000) | ((pc_reg + 32'd4) & 32'h7FFFFFFF);
      exp_req   = s_reset && !m_out && !ev && fifo_q.size() < 2;
      grant     = exp_req && s_gnt;
      exp_pcwr  = s_reset && (ev || grant);
      exp_pcin  = !exp_pcwr ? pc_reg : (ev ? target : seq);
      exp_valid = s_reset && fifo_q.size() != 0;

      checkOutput("imem_req", imem_req, exp_req);
      checkOutput("imem_addr", imem_addr, pc_reg);
      checkOutput("PCWr", PCWr, exp_pcwr);
      checkOutput("PC_in", PC_in, exp_pcin);
      checkOutput("id_valid", id_valid, exp_valid);
      if (exp_valid) begin
         checkOutput("id_pc", id_pc, fifo_q[0].pc);
         checkOutput("id_instr", id_instr, fifo_q[0].instr);
      end else if (!s_reset) begin
         checkOutput("rst_id_pc", id_pc, 32'd0);
         checkOutput("rst_id_instr", id_instr, 32'd0);
      end

      if (!s_reset) begin
         fifo_q.delete(); m_out = 0; m_discard = 0;
      end else begin
         if (exp_valid && s_ready) void'(fifo_q.pop_front());
         if (m_out && rv) begin
            if (!m_discard && !ev) fifo_q.push_back('{pc: m_req_pc, instr: rd});
            m_out = 0; m_discard = 0;
         end else if (m_out && ev) begin
            m_discard = 1;
         end
         if (ev) fifo_q.delete();
         if (grant) begin
            m_out = 1; m_req_pc = pc_reg;
         end
      end

      if (mem_pending) begin
         if (mem_cnt == 0) mem_pending = 0;
         else mem_cnt--;
      end
      if (grant) begin
         mem_pending = 1;
         mem_cnt  = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 2));
         mem_data = s_rdata_next;
      end
      if (exp_pcwr) pc_reg = exp_pcin;
   endtask

   task automatic doReset(input logic [31:0] start_pc);
      idleInputs();
      for (int i = 0; i < 10 && mem_pending; i++) runCycle();
      checkOutput("mem_drain", mem_pending, 1'b0);
      s_reset = 0; pc_reg = start_pc;
      runCycle();
      s_reset = 1;
   endtask

   task automatic applyStimulus();
      s_reset       = !(mem_pending == 0 && $urandom_range(0, 99) == 0);
      s_gnt         = $urandom_range(0, 9) < 7;
      s_ready       = $urandom_range(0, 9) < 6;
      s_redirect    = $urandom_range(0, 19) == 0;
      s_illop       = $urandom_range(0, 49) == 0;
      s_irq         = $urandom_range(0, 24) == 0;
      s_spurious    = $urandom_range(0, 9) == 0;
      s_redirect_pc = $urandom & 32'hFFFFFFFC;
      s_rdata_next  = $urandom;
      forced_lat    = -1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      idleInputs();
      s_reset = 0;
      for (int i = 0; i < 3; i++) runCycle();
      checkOutput("rst_valid", id_valid, 1'b0);
      checkOutput("rst_req", imem_req, 1'b0);

      // Streaming with single-cycle memory latency.
      doReset(32'h0);
      s_gnt = 1; forced_lat = 0;
      runCycle();
      checkOutput("stream_pcin0", PC_in, 32'h4);
      for (int i = 0; i < 9; i++) runCycle();

      // Backpressure fills the buffer, then a single pop lets fetching resume.
      s_ready = 0;
      for (int i = 0; i < 8; i++) runCycle();
      checkOutput("bp_req", imem_req, 1'b0);
      checkOutput("bp_valid", id_valid, 1'b1);
      s_ready = 1;
      for (int i = 0; i < 4; i++) runCycle();

      // Redirect while a response is outstanding.
      doReset(32'h200);
      s_gnt = 1; forced_lat = 1;
      runCycle();
      s_gnt = 0; s_redirect = 1; s_redirect_pc = 32'h100;
      runCycle();
      checkOutput("flush_pcwr", PCWr, 1'b1);
      checkOutput("flush_pcin", PC_in, 32'h100);
      s_redirect = 0; s_gnt = 1; forced_lat = 0;
      for (int i = 0; i < 4; i++) runCycle();
      checkOutput("flush_idpc", id_pc, 32'h100);

      // Priority and kernel-mode interrupt masking.
      doReset(32'h40);
      s_illop = 1; s_irq = 1; s_redirect = 1; s_redirect_pc = 32'h300; s_gnt = 1;
      runCycle();
      checkOutput("prio_pcin", PC_in, 32'h80000004);
      s_illop = 0; s_redirect = 0; s_gnt = 0; pc_reg = 32'h80000010;
      runCycle();
      checkOutput("irq_masked_pcwr", PCWr, 1'b0);
      checkOutput("irq_masked_pcin", PC_in, 32'h80000010);
      pc_reg = 32'h20;
      runCycle();
      checkOutput("irq_pcin", PC_in, XADR_V);
      s_irq = 0;

      // Sequential PC wrap in both halves of the address space.
      doReset(32'hFFFFFFFC);
      s_gnt = 1;
      runCycle();
      checkOutput("wrap_kernel", PC_in, 32'h80000000);
      doReset(32'h7FFFFFFC);
      s_gnt = 1;
      runCycle();
      checkOutput("wrap_user", PC_in, 32'h0);

      // Reset while waiting: the late response must be ignored.
      doReset(32'h1000);
      s_gnt = 1; forced_lat = 2; s_rdata_next = 32'hDEADBEEF;
      runCycle();
      s_gnt = 0; s_reset = 0;
      runCycle();
      s_reset = 1;
      runCycle();
      runCycle();
      checkOutput("late_rvalid", imem_rvalid, 1'b1);
      runCycle();
      checkOutput("late_valid", id_valid, 1'b0);

      doReset($urandom & 32'hFFFFFFFC);
      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         runCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
